// File: rtl/ram_alu_core.sv
// ram_alu_core
//   Storage and arithmetic core of the accumulator CPU. It holds a
//   single-port synchronous word RAM on a tri-state data bus, plus a
//   purely combinational ALU. The external sequencer issues one memory
//   or ALU action per clock.
//
// Ports
//   clk       rising-edge clock for all state
//   rst       synchronous active-high reset (clears the read register only)
//   addr      RAM word address, used as-is over the full range
//   data      bidirectional RAM data bus (driven only for cs & oe & ~we)
//   cs        chip select, active-high
//   we        write enable, active-high (selects write over read)
//   oe        output enable, active-high
//   alu_a     operand A (accumulator)
//   alu_b     operand B (memory operand)
//   alu_sel   operation select
//   alu_out   ALU result
//   alu_zero  high when alu_out is zero
module ram_alu_core #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int ALU_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ALU_WIDTH-1:0]  alu_a,
  input  logic [ALU_WIDTH-1:0]  alu_b,
  input  logic [3:0]            alu_sel,
  output logic [ALU_WIDTH-1:0]  alu_out,
  output logic                  alu_zero
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SHL  = 4'b0111;
  localparam logic [3:0] OP_SHR  = 4'b1000;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_reg;
  logic                  wr_en;
  logic                  rd_en;
  logic                  drive_en;

  // Write and read are mutually exclusive, decided by we; reset
  // suppresses both, but RAM contents survive reset.
  assign wr_en    = !rst && cs && we;
  assign rd_en    = cs && !we;
  assign drive_en = cs && oe && !we;

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= data;
    end
  end

  // Read register: one-clock read latency, holds while cs=0 or during writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_reg <= '0;
    end else if (rd_en) begin
      rd_reg <= mem[addr];
    end
  end

  // The bus follows cs/oe/we combinationally, so dropping oe releases it
  // in the same cycle while rd_reg keeps its value.
  assign data = drive_en ? rd_reg : {DATA_WIDTH{1'bz}};

  // Add/subtract wrap modulo 2**ALU_WIDTH; carry/borrow is dropped.
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      OP_PASS: alu_out = alu_a;
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_NOT:  alu_out = ~alu_a;
      OP_XOR:  alu_out = alu_a ^ alu_b;
      OP_SHL:  alu_out = {alu_a[ALU_WIDTH-2:0], 1'b0};
      OP_SHR:  alu_out = {1'b0, alu_a[ALU_WIDTH-1:1]};
      default: alu_out = '0;
    endcase
  end

  assign alu_zero = (alu_out == '0);

endmodule

// File: tb/tb_ram_alu_core.sv
// tb_ram_alu_core
//   Self-checking bench for ram_alu_core. The data bus is a pulled-up net,
//   so a released bus reads as all ones; directed checks keep rd_reg at
//   values other than 16'hFFFF wherever release must be distinguished.
module tb_ram_alu_core;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int LW = 12;
  localparam logic [DW-1:0] RELEASED = 16'hFFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  tri1  [DW-1:0] data;
  logic          cs, we, oe;
  logic [LW-1:0] alu_a, alu_b, alu_out;
  logic [3:0]    alu_sel;
  logic          alu_zero;

  logic          bus_en;
  logic [DW-1:0] bus_val;

  assign data = bus_en ? bus_val : {DW{1'bz}};

  always #5 clk = ~clk;

  ram_alu_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALU_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data),
    .cs(cs), .we(we), .oe(oe),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: memory image and the value last latched by a read.
  logic [DW-1:0] mref [0:(1<<AW)-1];
  logic [DW-1:0] rd_exp;

  typedef struct {
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic [3:0]    sel;
    logic [LW-1:0] exp;
    logic          zero;
  } alu_vec_t;

  alu_vec_t vecs [0:13];

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cs = 1'b1; we = 1'b1; oe = 1'b0; addr = a;
    bus_en = 1'b1; bus_val = d;
    tick();
    bus_en = 1'b0; we = 1'b0; cs = 1'b0;
    mref[a] = d;
  endtask

  task automatic mem_read(input logic [AW-1:0] a);
    bus_en = 1'b0;
    cs = 1'b1; we = 1'b0; oe = 1'b1; addr = a;
    tick();
    rd_exp = mref[a];
  endtask

  function automatic logic [LW-1:0] alu_ref(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                            input logic [3:0] sel);
    int ai = int'(a);
    int bi = int'(b);
    int m  = 1 << LW;
    case (sel)
      4'd0:    return a;
      4'd1:    return LW'((ai + bi) % m);
      4'd2:    return LW'((ai - bi + m) % m);
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return ~a;
      4'd6:    return a ^ b;
      4'd7:    return LW'((ai * 2) % m);
      4'd8:    return LW'(ai / 2);
      default: return '0;
    endcase
  endfunction

  logic [AW-1:0] pool [0:7];

  initial begin
    vecs[0]  = '{12'h001, 12'h001, 4'b0001, 12'h002, 1'b0};
    vecs[1]  = '{12'hFFF, 12'h001, 4'b0001, 12'h000, 1'b1};
    vecs[2]  = '{12'h000, 12'h001, 4'b0010, 12'hFFF, 1'b0};
    vecs[3]  = '{12'h00A, 12'h003, 4'b0010, 12'h007, 1'b0};
    vecs[4]  = '{12'h0F0, 12'h0FF, 4'b0011, 12'h0F0, 1'b0};
    vecs[5]  = '{12'h0F0, 12'h0FF, 4'b0100, 12'h0FF, 1'b0};
    vecs[6]  = '{12'h0F0, 12'h0FF, 4'b0101, 12'hF0F, 1'b0};
    vecs[7]  = '{12'h0F0, 12'h0FF, 4'b0110, 12'h00F, 1'b0};
    vecs[8]  = '{12'h801, 12'h0FF, 4'b0111, 12'h002, 1'b0};
    vecs[9]  = '{12'h801, 12'h0FF, 4'b1000, 12'h400, 1'b0};
    vecs[10] = '{12'h801, 12'h0FF, 4'b1111, 12'h000, 1'b1};
    vecs[11] = '{12'h5A5, 12'h123, 4'b0000, 12'h5A5, 1'b0};
    vecs[12] = '{12'h0F0, 12'h0F0, 4'b0010, 12'h000, 1'b1};
    vecs[13] = '{12'h801, 12'h0FF, 4'b1001, 12'h000, 1'b1};

    pool = '{12'h000, 12'hFFF, 12'h555, 12'hAAA, 12'h100, 12'h102, 12'h126, 12'h12A};

    rst = 1'b1; cs = 1'b1; we = 1'b0; oe = 1'b1; addr = '0;
    bus_en = 1'b0; bus_val = '0;
    alu_a = '0; alu_b = '0; alu_sel = '0;

    // Reset state: read register cleared and driven onto the bus.
    tick();
    tick();
    check("reset_bus", data, 16'h0000);
    rst = 1'b0; cs = 1'b0; oe = 1'b0;
    #1;
    check("idle_release", data, RELEASED);

    // Write then read back.
    mem_write(12'h100, 16'h1120);
    mem_write(12'h102, 16'h212A);
    mem_write(12'h126, 16'h000A);
    mem_read(12'h102);
    check("read_102", data, 16'h212A);
    mem_read(12'h100);
    check("read_100", data, 16'h1120);
    mem_read(12'h126);
    check("read_126", data, 16'h000A);

    // Bus release: rd_reg holds 0x000A.
    oe = 1'b0; #1;
    check("oe0_release", data, RELEASED);
    oe = 1'b1; #1;
    check("oe1_reappear", data, 16'h000A);
    cs = 1'b0; #1;
    check("cs0_release", data, RELEASED);
    cs = 1'b1; we = 1'b1; #1;
    check("we1_release", data, RELEASED);
    we = 1'b0; #1;
    check("restore_drive", data, 16'h000A);

    // oe dropped across a clock edge: released, value retained.
    mem_read(12'h100);
    oe = 1'b0;
    tick();
    check("oe_toggle_z", data, RELEASED);
    oe = 1'b1; #1;
    check("oe_toggle_back", data, 16'h1120);

    // Reset clears rd_reg, memory survives, write under reset is dropped.
    rst = 1'b1;
    tick();
    check("rst_clears", data, 16'h0000);
    rst = 1'b0;
    mem_read(12'h100);
    check("mem_kept", data, 16'h1120);
    rst = 1'b1; cs = 1'b1; we = 1'b1; oe = 1'b0; addr = 12'h100;
    bus_en = 1'b1; bus_val = 16'hDEAD;
    tick();
    bus_en = 1'b0; rst = 1'b0; we = 1'b0;
    rd_exp = '0;
    mem_read(12'h100);
    check("rst_write_dropped", data, 16'h1120);

    // Back-to-back write/read at the same address.
    mem_write(12'h12A, 16'h0001);
    mem_read(12'h12A);
    check("b2b_0001", data, 16'h0001);
    mem_write(12'h12A, 16'h0000);
    mem_read(12'h12A);
    check("b2b_0000", data, 16'h0000);

    // ALU table.
    for (int i = 0; i < 14; i++) begin
      alu_a = vecs[i].a; alu_b = vecs[i].b; alu_sel = vecs[i].sel;
      #1;
      check($sformatf("alu_vec%0d", i), 16'(alu_out), 16'(vecs[i].exp));
      check($sformatf("zero_vec%0d", i), 16'(alu_zero), 16'(vecs[i].zero));
    end

    // Random ALU against the reference.
    for (int i = 0; i < 200; i++) begin
      logic [LW-1:0] e;
      alu_a = LW'($urandom); alu_b = LW'($urandom); alu_sel = 4'($urandom_range(0, 15));
      e = alu_ref(alu_a, alu_b, alu_sel);
      #1;
      check("alu_rand", 16'(alu_out), 16'(e));
      check("zero_rand", 16'(alu_zero), 16'(e == '0));
    end

    // Random memory traffic over a small address pool including both ends.
    for (int i = 0; i < 8; i++) mem_write(pool[i], 16'($urandom_range(0, 16'hFFFE)));
    mem_read(pool[0]);
    check("pool_first", data, rd_exp);
    for (int i = 0; i < 400; i++) begin
      logic          c, w, o, r;
      logic [AW-1:0] a;
      logic [DW-1:0] v;
      c = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 2) == 0);
      o = w ? 1'b0 : 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 19) == 0);
      a = pool[$urandom_range(0, 7)];
      v = 16'($urandom);
      rst = r; cs = c; we = w; oe = o; addr = a;
      bus_en = w; bus_val = v;
      tick();
      if (r) rd_exp = '0;
      else if (c && w) mref[a] = v;
      else if (c) rd_exp = mref[a];
      if (!w) check("rand_bus", data, (c && o) ? rd_exp : RELEASED);
      bus_en = 1'b0; rst = 1'b0;
    end
    // Read every pool word back to catch corrupted storage.
    for (int i = 0; i < 8; i++) begin
      mem_read(pool[i]);
      check("pool_final", data, rd_exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
